// File: rtl/bcd_stopwatch_ctrl_pkg.sv
// Shared types and sizing for the BCD stopwatch controller.
package bcd_stopwatch_ctrl_pkg;

  localparam int unsigned DIGIT_W      = 4;
  localparam int unsigned NUM_DIGITS   = 4;
  localparam int unsigned DISP_W       = DIGIT_W * NUM_DIGITS;
  localparam int unsigned TICK_DIV_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_e;

endpackage

// File: rtl/bcd_stopwatch_ctrl_if.sv
// Command pulses and display/status bundle between a host and the stopwatch.
interface bcd_stopwatch_ctrl_if;
  import bcd_stopwatch_ctrl_pkg::*;

  logic              start_stop;
  logic              lap;
  logic              clear;
  logic [DISP_W-1:0] disp;
  logic              running;
  logic              lap_hold;
  logic              ovf;

  modport master (
    output start_stop, lap, clear,
    input  disp, running, lap_hold, ovf
  );

  modport slave (
    input  start_stop, lap, clear,
    output disp, running, lap_hold, ovf
  );
endinterface

// File: rtl/bcd_digit.sv
// One mod-10 BCD counter digit; carry fires combinationally on inc at 9.
module bcd_digit
  import bcd_stopwatch_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);

  localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(9);

  // Any out-of-range code folds back to 0 so a digit never exceeds 9.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= (q >= DIGIT_MAX) ? '0 : q + DIGIT_W'(1);
    end
  end

  assign carry = inc && (q >= DIGIT_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Four-digit BCD stopwatch: start/pause/resume, lap freeze, clear, sticky wrap flag.
module bcd_stopwatch_ctrl
  import bcd_stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  bcd_stopwatch_ctrl_if.slave  bus
);

  localparam int unsigned      PRESC_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

  state_e              state_q;
  state_e              state_d;
  logic [PRESC_W-1:0]  presc_q;
  logic [DISP_W-1:0]   count;
  logic [DISP_W-1:0]   snap_q;
  logic [NUM_DIGITS:0] carry;
  logic                ovf_q;
  logic                active;
  logic                tick;
  logic                take_lap;
  logic                restart;

  assign active   = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign tick     = active && (presc_q == PRESC_MAX);
  assign take_lap = bus.lap && !bus.clear && !bus.start_stop && (state_q == ST_RUN);
  assign restart  = bus.start_stop && (state_q == ST_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: clear beats start_stop beats lap
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = ST_IDLE;
    end else if (bus.start_stop) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        ST_LAP:   state_d = ST_PAUSE;
        default:  state_d = ST_IDLE;
      endcase
    end else if (bus.lap) begin
      case (state_q)
        ST_RUN:  state_d = ST_LAP;
        ST_LAP:  state_d = ST_RUN;
        default: state_d = state_q;
      endcase
    end
  end

  // Prescaler advances from the pre-transition state; a pause keeps its phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else if (bus.clear || restart) begin
      presc_q <= '0;
    end else if (active) begin
      presc_q <= tick ? '0 : presc_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q <= '0;
    end else if (bus.clear) begin
      snap_q <= '0;
    end else if (take_lap) begin
      snap_q <= count;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (bus.clear) begin
      ovf_q <= 1'b0;
    end else if (carry[NUM_DIGITS]) begin
      ovf_q <= 1'b1;
    end
  end

  assign carry[0] = tick;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .reset (reset),
      .clr   (bus.clear),
      .inc   (carry[i]),
      .q     (count[i*DIGIT_W +: DIGIT_W]),
      .carry (carry[i+1])
    );
  end

  assign bus.disp     = (state_q == ST_LAP) ? snap_q : count;
  assign bus.running  = active;
  assign bus.lap_hold = (state_q == ST_LAP);
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Directed and randomized checks of bcd_stopwatch_ctrl against an integer-count model.
module tb_bcd_stopwatch_ctrl;

  localparam int TD = 4;

  logic clk;
  logic reset;

  bcd_stopwatch_ctrl_if bus ();

  bcd_stopwatch_ctrl #(.TICK_DIV(TD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: elapsed ticks as a plain integer, mode as a small code.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;
  int m_mode, m_count, m_snap, m_phase;
  bit m_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int d;
    r = '0;
    d = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(d % 10);
      d = d / 10;
    end
    return r;
  endfunction

  task automatic model_update(input bit rs, input bit cl, input bit ss, input bit lp);
    bit moving, tick;
    int nmode;
    if (rs || cl) begin
      m_mode = M_IDLE; m_count = 0; m_snap = 0; m_phase = 0; m_ovf = 0;
      return;
    end
    moving = (m_mode == M_RUN) || (m_mode == M_LAP);
    tick   = moving && (m_phase == TD - 1);
    nmode  = m_mode;
    if (moving) m_phase = (m_phase + 1) % TD;
    if (ss) begin
      if (m_mode == M_IDLE) begin nmode = M_RUN; m_phase = 0; end
      else if (m_mode == M_PAUSE) nmode = M_RUN;
      else nmode = M_PAUSE;
    end else if (lp) begin
      if (m_mode == M_RUN) begin nmode = M_LAP; m_snap = m_count; end
      else if (m_mode == M_LAP) nmode = M_RUN;
    end
    if (tick) begin
      if (m_count == 9999) m_ovf = 1;
      m_count = (m_count + 1) % 10000;
    end
    m_mode = nmode;
  endtask

  task automatic check_model();
    chk("disp", 32'(bus.disp), 32'(to_bcd(m_mode == M_LAP ? m_snap : m_count)));
    chk("running", 32'(bus.running), 32'((m_mode == M_RUN) || (m_mode == M_LAP)));
    chk("lap_hold", 32'(bus.lap_hold), 32'(m_mode == M_LAP));
    chk("ovf", 32'(bus.ovf), 32'(m_ovf));
  endtask

  task automatic step(input bit rs, input bit cl, input bit ss, input bit lp);
    reset = rs; bus.clear = cl; bus.start_stop = ss; bus.lap = lp;
    @(posedge clk);
    model_update(rs, cl, ss, lp);
    #1;
    reset = 1'b0; bus.clear = 1'b0; bus.start_stop = 1'b0; bus.lap = 1'b0;
    check_model();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; bus.clear = 1'b0; bus.start_stop = 1'b0; bus.lap = 1'b0;
    m_mode = M_IDLE; m_count = 0; m_snap = 0; m_phase = 0; m_ovf = 0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_disp", 32'(bus.disp), 32'h0000);
    chk("rst_running", 32'(bus.running), 32'd0);
    chk("rst_lap_hold", 32'(bus.lap_hold), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);

    // Start and basic tick timing
    step(0, 0, 1, 0);
    chk("start_running", 32'(bus.running), 32'd1);
    idle_steps(3);
    chk("pre_first_tick", 32'(bus.disp), 32'h0000);
    step(0, 0, 0, 0);
    chk("first_tick", 32'(bus.disp), 32'h0001);
    idle_steps(36);
    chk("tick_ten", 32'(bus.disp), 32'h0010);

    // Run up to 9999, then wrap
    for (int i = 0; i < 45000 && m_count != 9999; i++) step(0, 0, 0, 0);
    chk("reach_9999", 32'(bus.disp), 32'h9999);
    chk("no_ovf_yet", 32'(bus.ovf), 32'd0);
    for (int i = 0; i < TD && m_count == 9999; i++) step(0, 0, 0, 0);
    chk("wrap_disp", 32'(bus.disp), 32'h0000);
    chk("wrap_ovf", 32'(bus.ovf), 32'd1);
    idle_steps(TD * 3);
    chk("ovf_sticky", 32'(bus.ovf), 32'd1);

    // clear + start_stop + lap together in RUN
    step(0, 1, 1, 1);
    chk("clr_disp", 32'(bus.disp), 32'h0000);
    chk("clr_ovf", 32'(bus.ovf), 32'd0);
    chk("clr_running", 32'(bus.running), 32'd0);

    // Lap freeze and release
    step(0, 0, 1, 0);
    idle_steps(20);
    chk("lap_pre", 32'(bus.disp), 32'h0005);
    step(0, 0, 0, 1);
    chk("lap_hold_on", 32'(bus.lap_hold), 32'd1);
    idle_steps(12);
    chk("lap_frozen", 32'(bus.disp), 32'h0005);
    chk("lap_still_held", 32'(bus.lap_hold), 32'd1);
    step(0, 0, 0, 1);
    chk("lap_release", 32'(bus.disp), 32'h0008);
    chk("lap_hold_off", 32'(bus.lap_hold), 32'd0);

    // Pause keeps prescaler phase
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    idle_steps(4);
    chk("pause_first_tick", 32'(bus.disp), 32'h0001);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("paused_running", 32'(bus.running), 32'd0);
    idle_steps(20);
    chk("paused_frozen", 32'(bus.disp), 32'h0001);
    step(0, 0, 1, 0);
    chk("resumed_running", 32'(bus.running), 32'd1);
    step(0, 0, 0, 0);
    chk("resume_plus1", 32'(bus.disp), 32'h0001);
    step(0, 0, 0, 0);
    chk("resume_plus2", 32'(bus.disp), 32'h0002);

    // Reset mid-LAP
    step(0, 0, 0, 1);
    idle_steps(5);
    chk("in_lap", 32'(bus.lap_hold), 32'd1);
    step(1, 0, 1, 1);
    chk("rst_lap_disp", 32'(bus.disp), 32'h0000);
    chk("rst_lap_running", 32'(bus.running), 32'd0);
    chk("rst_lap_hold", 32'(bus.lap_hold), 32'd0);
    chk("rst_lap_ovf", 32'(bus.ovf), 32'd0);

    // Random command soup
    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 300) == 0, ($urandom % 80) == 0,
           ($urandom % 12) == 0, ($urandom % 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
